// File: rtl/blowfish_feistel_core.sv
// -----------------------------------------------------------------------------
// blowfish_feistel_core
//   Blowfish Feistel engine for the bcrypt datapath. Encrypts or decrypts one
//   64-bit block (L,R) over ROUNDS rounds. P-array and S-boxes live in an
//   external SRAM with two read ports (A,B) of 1-cycle latency: an address
//   driven during a cycle returns its data during the following cycle.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     block request handshake (in_ready only in IDLE)
//   decrypt, L_in, R_in     mode and input halves, sampled at accept
//   out_valid / out_ready   result handshake; result held until consumed
//   resultL, resultR        result halves
//   addr_a/b, cs_a_l/b_l    SRAM read address and active-low chip select
//   we_a_l/b_l, oe_a_l/b_l  SRAM write/output enables (read-only use)
//   data_out_a/b            SRAM read data
// -----------------------------------------------------------------------------
module blowfish_feistel_core #(
  parameter int ROUNDS = 16,
  parameter int ADDR_W = 12,
  parameter int S_BASE = 0,
  parameter int P_BASE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              decrypt,
  input  logic [31:0]       L_in,
  input  logic [31:0]       R_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       resultL,
  output logic [31:0]       resultR,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              cs_a_l,
  output logic              cs_b_l,
  output logic              we_a_l,
  output logic              we_b_l,
  output logic              oe_a_l,
  output logic              oe_b_l,
  input  logic [31:0]       data_out_a,
  input  logic [31:0]       data_out_b
);

  localparam int RW = $clog2(ROUNDS + 2);
  localparam logic [ADDR_W-1:0] S_BASE_A = ADDR_W'(S_BASE);
  localparam logic [ADDR_W-1:0] P_BASE_A = ADDR_W'(P_BASE);
  localparam logic [RW-1:0]     LAST_R   = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_XP, S_SA, S_SB, S_MX, S_FIN, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q, f_q;
  logic [31:0] res_l_q, res_r_q;
  logic [RW-1:0] round_q;
  logic        dec_q;

  logic              issue_a, issue_b;
  logic [ADDR_W-1:0] a_addr, b_addr;

  // P-array word address for round index r, reversed order when decrypting.
  function automatic logic [ADDR_W-1:0] p_addr(input logic [RW-1:0] r, input logic dec);
    logic [RW-1:0] idx;
    idx = dec ? (RW'(ROUNDS + 1) - r) : r;
    return P_BASE_A + ADDR_W'(idx);
  endfunction

  // S-box k entry b lives at S_BASE + 256*k + b.
  function automatic logic [ADDR_W-1:0] s_addr(input logic [1:0] k, input logic [7:0] b);
    return S_BASE_A + ADDR_W'({k, b});
  endfunction

  // Addresses are issued combinationally in the cycle before their data is
  // consumed; the accept cycle itself issues the first P read.
  always_comb begin
    state_d  = state_q;
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    in_ready = (state_q == S_IDLE) && !reset;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_XP;
          issue_a = 1'b1;
          a_addr  = p_addr('0, decrypt);
        end
      end
      S_XP: state_d = S_SA;
      S_SA: begin
        state_d = S_SB;
        issue_a = 1'b1;
        issue_b = 1'b1;
        a_addr  = s_addr(2'd0, l_q[31:24]);
        b_addr  = s_addr(2'd1, l_q[23:16]);
      end
      S_SB: begin
        state_d = S_MX;
        issue_a = 1'b1;
        issue_b = 1'b1;
        a_addr  = s_addr(2'd2, l_q[15:8]);
        b_addr  = s_addr(2'd3, l_q[7:0]);
      end
      S_MX: begin
        issue_a = 1'b1;
        if (round_q == LAST_R) begin
          state_d = S_FIN;
          issue_b = 1'b1;
          a_addr  = p_addr(RW'(ROUNDS), dec_q);
          b_addr  = p_addr(RW'(ROUNDS + 1), dec_q);
        end else begin
          state_d = S_XP;
          a_addr  = p_addr(round_q + RW'(1), dec_q);
        end
      end
      S_FIN: state_d = S_OUT;
      S_OUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      f_q     <= '0;
      res_l_q <= '0;
      res_r_q <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            l_q     <= L_in;
            r_q     <= R_in;
            dec_q   <= decrypt;
            round_q <= '0;
          end
        end
        S_XP: l_q <= l_q ^ data_out_a;
        S_SB: f_q <= data_out_a + data_out_b;
        S_MX: begin
          l_q <= r_q ^ ((f_q ^ data_out_a) + data_out_b);
          r_q <= l_q;
          if (round_q != LAST_R) round_q <= round_q + RW'(1);
        end
        // Final swap is undone here: L pairs with the last P word, R with the one before.
        S_FIN: begin
          res_l_q <= r_q ^ data_out_b;
          res_r_q <= l_q ^ data_out_a;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign resultL   = res_l_q;
  assign resultR   = res_r_q;
  assign addr_a    = a_addr;
  assign addr_b    = b_addr;
  assign cs_a_l    = ~issue_a;
  assign cs_b_l    = ~issue_b;
  assign we_a_l    = 1'b1;
  assign we_b_l    = 1'b1;
  assign oe_a_l    = 1'b0;
  assign oe_b_l    = 1'b0;

endmodule
